// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register bank, applies writeback bypass and a busy
// scoreboard to stall readers of in-flight destinations, and registers one operand packet.
module operand_fetch #(
   parameter int unsigned DW = 64,
   parameter int unsigned AW = 5
) (
   input  logic          CLK,
   input  logic          RST,
   // decoded instruction
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rn,
   input  logic [AW-1:0] in_rm,
   input  logic [AW-1:0] in_rd,
   input  logic          in_use_imm,
   input  logic [DW-1:0] in_imm,
   input  logic          in_regwrite,
   input  logic [10:0]   in_op,
   // register bank read ports
   output logic [AW-1:0] A,
   output logic [AW-1:0] B,
   input  logic [DW-1:0] Adata,
   input  logic [DW-1:0] Bdata,
   // writeback port
   input  logic          wb_we,
   input  logic [AW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   // operand packet
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_opa,
   output logic [DW-1:0] out_opb,
   output logic [AW-1:0] out_rd,
   output logic [10:0]   out_op,
   output logic          out_regwrite
);

   localparam int unsigned NumRegs = 2 ** AW;
   localparam logic [AW-1:0] ZeroReg = '1;

   logic [NumRegs-1:0] busy_q, busy_d;
   logic               valid_q;
   logic [DW-1:0]      opa_q, opb_q;
   logic [AW-1:0]      rd_q;
   logic [10:0]        op_q;
   logic               regwrite_q;

   logic [DW-1:0] opa_res, opb_res;
   logic          wb_hit_rn, wb_hit_rm;
   logic          hazard_rn, hazard_rm, hazard;
   logic          accept;

   assign A = in_rn;
   assign B = in_rm;

   assign wb_hit_rn = wb_we && (wb_rd == in_rn) && (wb_rd != ZeroReg);
   assign wb_hit_rm = wb_we && (wb_rd == in_rm) && (wb_rd != ZeroReg);

   always_comb begin
      opa_res = Adata;
      if (in_rn == ZeroReg) begin
         opa_res = '0;
      end else if (wb_hit_rn) begin
         opa_res = wb_data;
      end

      opb_res = Bdata;
      if (in_use_imm) begin
         opb_res = in_imm;
      end else if (in_rm == ZeroReg) begin
         opb_res = '0;
      end else if (wb_hit_rm) begin
         opb_res = wb_data;
      end
   end

   // A writeback landing this cycle resolves the hazard through the bypass.
   assign hazard_rn = busy_q[in_rn] && !wb_hit_rn;
   assign hazard_rm = !in_use_imm && busy_q[in_rm] && !wb_hit_rm;
   assign hazard    = hazard_rn || hazard_rm;

   assign in_ready = (!valid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   // Clear first, then set: a same-cycle new writer is younger and must stay tracked.
   always_comb begin
      busy_d = busy_q;
      if (wb_we && (wb_rd != ZeroReg)) begin
         busy_d[wb_rd] = 1'b0;
      end
      if (accept && in_regwrite && (in_rd != ZeroReg)) begin
         busy_d[in_rd] = 1'b1;
      end
      busy_d[ZeroReg] = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         busy_q     <= '0;
         valid_q    <= 1'b0;
         opa_q      <= '0;
         opb_q      <= '0;
         rd_q       <= '0;
         op_q       <= '0;
         regwrite_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         if (accept) begin
            valid_q    <= 1'b1;
            opa_q      <= opa_res;
            opb_q      <= opb_res;
            rd_q       <= in_rd;
            op_q       <= in_op;
            regwrite_q <= in_regwrite;
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign out_valid    = valid_q;
   assign out_opa      = opa_q;
   assign out_opb      = opb_q;
   assign out_rd       = rd_q;
   assign out_op       = op_q;
   assign out_regwrite = regwrite_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DW, default 64, operand/register data width.
REQ-002 Parameter AW, default 5, register address width (32 registers; register 31 = XZR).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  decoded instruction present.
REQ-006 in_ready  output  1  block accepts instruction this cycle.
REQ-007 in_rn, in_rm, in_rd  input  AW each  source 1, source 2, destination register numbers.
REQ-008 in_use_imm  input  1  operand B taken from in_imm instead of register rm.
REQ-009 in_imm  input  DW  sign-extended immediate.
REQ-010 in_regwrite  input  1  instruction will write in_rd.
REQ-011 in_op  input  11  opcode, passed through unchanged.
REQ-012 A, B  output  AW each  register-bank read addresses (combinational from in_rn, in_rm).
REQ-013 Adata, Bdata  input  DW each  register-bank read data, combinational with A/B.
REQ-014 wb_we, wb_rd, wb_data  input  1/AW/DW  writeback port, same values driving bank W/C/Cdata.
REQ-015 out_valid  output  1  operand packet valid.
REQ-016 out_ready  input  1  downstream accepts packet.
REQ-017 out_opa, out_opb  output  DW each  resolved operands.
REQ-018 out_rd, out_op, out_regwrite  output  AW/11/1  registered pass-through.

Function
REQ-019 A SHALL equal in_rn and B SHALL equal in_rm every cycle, independent of handshake.
REQ-020 Operand resolution: register 31 reads 0; else, if wb_we and wb_rd == source register and wb_rd != 31, wb_data (bypass); else, bank data.
REQ-021 out_opb SHALL be in_imm when in_use_imm is 1; rm then plays no part in hazard checks.
REQ-022 Block SHALL hold a 32-bit busy scoreboard; bit 31 permanently 0.
REQ-023 hazard = (busy[in_rn] and not (wb_we and wb_rd == in_rn)) or the same for in_rm when in_use_imm is 0.
REQ-024 in_ready = (not out_valid or out_ready) and not hazard.
REQ-025 Accept = in_valid and in_ready; on accept, output registers load resolved operands and pass-through fields, and out_valid becomes 1 at the next edge (1-cycle latency).
REQ-026 When out_valid and out_ready and no accept, out_valid SHALL clear at the next edge.
REQ-027 When out_valid and not out_ready, all output registers SHALL hold stable.
REQ-028 On accept with in_regwrite and in_rd != 31, busy[in_rd] SHALL set.
REQ-029 On wb_we with wb_rd != 31, busy[wb_rd] SHALL clear.
REQ-030 Same-cycle set and clear of the same bit: set wins, because the new writer is younger.
REQ-031 Back-to-back accepts SHALL sustain 1 instruction per cycle when hazard-free and out_ready is held at 1.
REQ-032 Writeback to a register that is not busy SHALL still bypass (REQ-020) and SHALL leave the scoreboard unchanged.

Reset
REQ-033 While RST is high at an edge: out_valid=0, busy=0, out_opa=out_opb=0, out_rd=0, out_op=0, out_regwrite=0.
REQ-034 in_ready during reset cycles SHALL follow REQ-024 evaluated on the reset state, with no accept taking effect; an instruction presented mid-operation while RST is high is dropped.

Verification
REQ-035 Reset, then in_rn=1, in_rm=2, bank X1=5, X2=7, out_ready=1 -> next cycle out_valid=1, out_opa=5, out_opb=7.
REQ-036 in_rn=31, in_use_imm=1, in_imm=0xFFFF_FFFF_FFFF_FFF0 -> out_opa=0, out_opb=0xFFFF_FFFF_FFFF_FFF0.
REQ-037 Bank X3=1 with wb_we=1, wb_rd=3, wb_data=9 in the same cycle as a read of X3 -> out_opa=9.
REQ-038 Accept ADD with rd=4, regwrite=1; next instruction reads X4 -> in_ready=0 until wb_we=1, wb_rd=4, wb_data=0x2A; on that cycle accept occurs with out_opa=0x2A and busy[4] cleared.
REQ-039 out_ready=0 for 3 cycles with packet P held and in_valid=1 -> out_* stable at P, in_ready=0; out_ready=1 -> next packet loads on the following edge.
REQ-040 RST asserted while busy[4]=1 and out_valid=1 -> next cycle busy=0, out_valid=0, and a read of X4 is accepted immediately.
